alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between NREQ requesters (e.g. execute stage, address-generation, multi-cycle helper units). Each accepted request is registered, driven onto the ALU for one cycle, and the captured result, zero and overflow flags are returned to the granted requester over a valid/ready response handshake. One operation is in flight at a time. Arbitration is round-robin or fixed-priority, selected at compile time.

## Interface
- NREQ, 2, number of requesters (2..4)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request strobe
- req_ready  output  NREQ  one-hot grant/accept; reset 0
- req_ctl  input  4*NREQ  ALU control code, requester i at [4i+3:4i]
- req_a  input  32*NREQ  operand a, requester i at [32i+31:32i]
- req_b  input  32*NREQ  operand b, same packing
- resp_valid  output  NREQ  one-hot response strobe to owner; reset 0
- resp_ready  input  NREQ  per-requester response accept
- resp_data  output  32  captured ALU result; reset 0
- resp_zero  output  1  captured zero flag; reset 0
- resp_ovf  output  1  captured overflow flag; reset 0
- alu_ctl  output  4  to ALU; from operand register; reset 4'b0000
- alu_a  output  32  to ALU; reset 0
- alu_b  output  32  to ALU; reset 0
- alu_out  input  32  ALU result
- alu_zero  input  1  ALU zero flag
- alu_overflow  input  1  ALU overflow flag (add 0010 / sub 0011 only)

## Operation
- FSM states: IDLE, EXEC, RESP. Reset -> IDLE, owner=0, operand/result registers 0, RR pointer = NREQ-1.
- IDLE: if any req_valid, winner w chosen combinationally; req_ready[w]=1 this cycle only; ctl/a/b of w latched, owner<=w, next EXEC. No valid -> stay IDLE, req_ready=0.
- req_ready is asserted only in IDLE, only to a requester with req_valid=1; handshake = valid&ready same cycle.
- EXEC: operand registers drive ALU; alu_out/alu_zero/alu_overflow captured into result registers; next RESP. Unconditional, one cycle.
- RESP: resp_valid[owner]=1, resp_data/zero/ovf stable; held until resp_ready[owner]=1, then next IDLE. resp_ready of non-owners ignored.
- Control codes passed through unmodified; undefined codes yield ALU result 0, zero=1, ovf=0 — not flagged by the arbiter.
- Requester may drop req_valid before grant without effect; operands need only be valid in the grant cycle.
- Result registers retain last value outside RESP; resp_valid is the only qualifier.
- Reset in any state (including EXEC/RESP mid-operation): in-flight op discarded, no response issued, all outputs to reset values next cycle.

## Timing
- Grant at cycle T (IDLE), EXEC at T+1, resp_valid at T+2 at earliest.
- Response accepted at cycle R -> IDLE at R+1 -> next grant at R+1 earliest; peak throughput 1 op per 3 cycles.
- req_ready depends combinationally on req_valid and state; all other outputs are registered.
- ALU path is combinational between alu_a/alu_b/alu_ctl and alu_out; must close within one cycle.

## Configuration
- ALU_ARB_RR_EN defined: round-robin; search starts at pointer+1 mod NREQ, pointer <= w on each grant.
- ALU_ARB_RR_EN undefined: fixed priority, lowest index with req_valid wins; pointer logic absent.

## Structure
- alu_pkg: ALU control code constants (ALU_AND 0000, ALU_OR 0001, ALU_ADD 0010, ALU_SUB 0011, ALU_SLT 0110, ALU_SLTU 0111, ALU_SLL 1000, ALU_SRL 1001, ALU_SRA 1010, ALU_XOR 1100, ALU_NOR 1101, ALU_LUI 1110), FSM state encoding, NREQ bounds.
- One sub-module: arb_picker — combinational one-hot winner from req_valid and pointer (pointer input ignored under fixed priority).

## Test plan
- Req0: ctl 0010, a 0x7FFFFFFF, b 0x00000001 -> resp_valid[0] at T+2, resp_data 0x80000000, resp_ovf 1, resp_zero 0.
- Req1: ctl 0011, a 5, b 5 -> resp_valid[1], resp_data 0, resp_zero 1, resp_ovf 0.
- Req0 and req1 held valid continuously, resp_ready tied 1: RR_EN grants 0,1,0,1 at 3-cycle spacing; without macro grants 0,0,0.
- Req0 ctl 1110, b 0x00001234, resp_ready[0] low 4 cycles -> resp_valid[0] and resp_data 0x12340000 held stable 4 cycles, IDLE one cycle after accept, no grant during RESP.
- Reset pulsed during EXEC of req1 op -> no resp_valid, all outputs 0 next cycle, next simultaneous request granted to req0.
- Req0 ctl 1111 (undefined), a 0xFFFFFFFF -> resp_data 0, resp_zero 1, resp_ovf 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU control codes, arbiter FSM encoding and NREQ bounds.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int NREQ_MIN = 2;
   localparam int NREQ_MAX = 4;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_XOR  = 4'b1100;
   localparam logic [3:0] ALU_NOR  = 4'b1101;
   localparam logic [3:0] ALU_LUI  = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Requester index width; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Requester request/response bus plus the shared-ALU port.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [4*NREQ-1:0]    req_ctl;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic [NREQ-1:0]      resp_valid;
   logic [NREQ-1:0]      resp_ready;
   logic [31:0]          resp_data;
   logic                 resp_zero;
   logic                 resp_ovf;
   logic [3:0]           alu_ctl;
   logic [31:0]          alu_a;
   logic [31:0]          alu_b;
   logic [31:0]          alu_out;
   logic                 alu_zero;
   logic                 alu_overflow;

   modport slave (
      input  req_valid, req_ctl, req_a, req_b, resp_ready,
             alu_out, alu_zero, alu_overflow,
      output req_ready, resp_valid, resp_data, resp_zero, resp_ovf,
             alu_ctl, alu_a, alu_b
   );

   modport master (
      output req_valid, req_ctl, req_a, req_b, resp_ready,
             alu_out, alu_zero, alu_overflow,
      input  req_ready, resp_valid, resp_data, resp_zero, resp_ovf,
             alu_ctl, alu_a, alu_b
   );
endinterface
`default_nettype wire

// File: rtl/arb_picker.sv
`default_nettype none
// ============================================================================
// Module   : arb_picker
// Purpose  : One-hot winner from request vector. ALU_ARB_RR_EN selects
//            round-robin (search from ptr+1); otherwise lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module arb_picker
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [PW-1:0]   idx_o
);

`ifdef ALU_ARB_RR_EN
   logic w_found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      w_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && valid_i[(int'(ptr_i) + k) % NREQ]) begin
            w_found = 1'b1;
            grant_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
            idx_o   = PW'((int'(ptr_i) + k) % NREQ);
         end
      end
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = ^ptr_i;

   // Scanning downward lets the lowest valid index overwrite the rest.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (valid_i[k]) begin
            grant_o    = '0;
            grant_o[k] = 1'b1;
            idx_o      = PW'(k);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU among NREQ requesters, one op in
//            flight. Define ALU_ARB_RR_EN for round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);

   localparam int PW = idx_width(NREQ);

   state_t            state_q, state_d;
   logic [PW-1:0]     owner_q;
   logic [3:0]        ctl_q;
   logic [31:0]       a_q, b_q, data_q;
   logic              zero_q, ovf_q;
   logic [NREQ-1:0]   resp_valid_q;

   logic [NREQ-1:0]   w_grant, w_req_ready;
   logic [PW-1:0]     w_idx, w_ptr;
   logic              w_load, w_capture, w_accept;

   arb_picker #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_picker (
      .valid_i (bus.req_valid),
      .ptr_i   (w_ptr),
      .grant_o (w_grant),
      .idx_o   (w_idx)
   );

`ifdef ALU_ARB_RR_EN
   logic [PW-1:0] ptr_q;

   // Pointer starts at NREQ-1 so requester 0 is searched first after reset.
   always_ff @(posedge clk) begin
      if (reset)       ptr_q <= PW'(NREQ - 1);
      else if (w_load) ptr_q <= w_idx;
   end
   assign w_ptr = ptr_q;
`else
   assign w_ptr = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (|bus.req_valid)          state_d = ST_EXEC;
         ST_EXEC:                              state_d = ST_RESP;
         ST_RESP: if (bus.resp_ready[owner_q]) state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready = '0;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            w_req_ready = w_grant;
            w_load      = |bus.req_valid;
         end
         ST_EXEC: w_capture = 1'b1;
         ST_RESP: w_accept  = bus.resp_ready[owner_q];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q      <= '0;
         ctl_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         data_q       <= '0;
         zero_q       <= 1'b0;
         ovf_q        <= 1'b0;
         resp_valid_q <= '0;
      end else begin
         if (w_load) begin
            owner_q <= w_idx;
            ctl_q   <= bus.req_ctl[{w_idx, 2'b00} +: 4];
            a_q     <= bus.req_a[{w_idx, 5'b00000} +: 32];
            b_q     <= bus.req_b[{w_idx, 5'b00000} +: 32];
         end
         if (w_capture) begin
            data_q       <= bus.alu_out;
            zero_q       <= bus.alu_zero;
            ovf_q        <= bus.alu_overflow;
            resp_valid_q <= NREQ'(1) << owner_q;
         end else if (w_accept) begin
            resp_valid_q <= '0;
         end
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = data_q;
   assign bus.resp_zero  = zero_q;
   assign bus.resp_ovf   = ovf_q;
   assign bus.alu_ctl    = ctl_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed scoreboard bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NREQ(NREQ)) bus ();

   alu_arbiter #(.NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] m_sum, m_dif;
   assign m_sum = bus.alu_a + bus.alu_b;
   assign m_dif = bus.alu_a - bus.alu_b;

   always_comb begin
      bus.alu_overflow = 1'b0;
      case (bus.alu_ctl)
         ALU_AND:  bus.alu_out = bus.alu_a & bus.alu_b;
         ALU_OR:   bus.alu_out = bus.alu_a | bus.alu_b;
         ALU_ADD: begin
            bus.alu_out      = m_sum;
            bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (m_sum[31] != bus.alu_a[31]);
         end
         ALU_SUB: begin
            bus.alu_out      = m_dif;
            bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (m_dif[31] != bus.alu_a[31]);
         end
         ALU_SLT:  bus.alu_out = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
         ALU_SLTU: bus.alu_out = {31'b0, bus.alu_a < bus.alu_b};
         ALU_SLL:  bus.alu_out = bus.alu_a << bus.alu_b[4:0];
         ALU_SRL:  bus.alu_out = bus.alu_a >> bus.alu_b[4:0];
         ALU_SRA:  bus.alu_out = $signed(bus.alu_a) >>> bus.alu_b[4:0];
         ALU_XOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
         ALU_NOR:  bus.alu_out = ~(bus.alu_a | bus.alu_b);
         ALU_LUI:  bus.alu_out = {bus.alu_b[15:0], 16'h0000};
         default:  bus.alu_out = 32'h0;
      endcase
      bus.alu_zero = (bus.alu_out == 32'h0);
   end

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        zero;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   g_idx[$];
   int   g_cyc[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NREQ; k++)
            if (bus.req_valid[k] && bus.req_ready[k]) begin
               g_idx.push_back(k);
               g_cyc.push_back(cyc);
            end
      end
   end

   // Scoreboard monitor: pops one expectation per response handshake.
   always @(negedge clk) begin
      if (!reset && bus.resp_valid != '0) begin
         check("resp_onehot", 32'($countones(bus.resp_valid)), 32'd1);
         for (int k = 0; k < NREQ; k++) begin
            if (bus.resp_valid[k] && bus.resp_ready[k]) begin
               if (sb.size() == 0) begin
                  check("unexpected_resp", 32'(bus.resp_valid), 32'h0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("resp_owner", 32'(k), 32'(e.idx));
                  check("resp_data", bus.resp_data, e.data);
                  check("resp_zero", 32'(bus.resp_zero), 32'(e.zero));
                  check("resp_ovf", 32'(bus.resp_ovf), 32'(e.ovf));
               end
            end
         end
      end
   end

   task automatic drive_req(input int i, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid[i]       = 1'b1;
      bus.req_ctl[4*i +: 4]  = ctl;
      bus.req_a[32*i +: 32]  = a;
      bus.req_b[32*i +: 32]  = b;
   endtask

   // Returns one cycle after the grant edge, i.e. during EXEC.
   task automatic issue(input int i, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic z, input logic o, input bit push);
      bit granted = 1'b0;
      if (push) sb.push_back('{i, d, z, o});
      drive_req(i, ctl, a, b);
      #1;
      for (int t = 0; t < 20; t++) begin
         if (bus.req_ready[i]) begin
            granted = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!granted) check("grant_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge clk);
      #1;
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"},  32'(bus.req_ready), 32'h0);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
      check({tag, "_resp_data"},  bus.resp_data, 32'h0);
      check({tag, "_resp_zero"},  32'(bus.resp_zero), 32'h0);
      check({tag, "_resp_ovf"},   32'(bus.resp_ovf), 32'h0);
      check({tag, "_alu_ctl"},    32'(bus.alu_ctl), 32'h0);
      check({tag, "_alu_a"},      bus.alu_a, 32'h0);
      check({tag, "_alu_b"},      bus.alu_b, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_order[4];
      bus.req_valid  = '0;
      bus.req_ctl    = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = '1;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Signed add overflow from requester 0, with T+1/T+2 timing.
      issue(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
      check("exec_no_resp", 32'(bus.resp_valid), 32'h0);
      check("exec_alu_ctl", 32'(bus.alu_ctl), 32'(ALU_ADD));
      check("exec_alu_a", bus.alu_a, 32'h7FFF_FFFF);
      @(posedge clk); #1;
      check("resp_at_t2", 32'(bus.resp_valid), 32'h1);
      drain();

      issue(1, ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b1);
      drain();

      // LUI with the response held off for four cycles.
      bus.resp_ready[0] = 1'b0;
      issue(0, ALU_LUI, 32'h0, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive_req(1, ALU_OR, 32'h1, 32'h2);
      for (int t = 0; t < 4; t++) begin
         check("stall_resp_valid", 32'(bus.resp_valid), 32'h1);
         check("stall_resp_data", bus.resp_data, 32'h1234_0000);
         check("stall_no_grant", 32'(bus.req_ready), 32'h0);
         @(posedge clk); #1;
      end
      bus.resp_ready[0] = 1'b1;
      bus.req_valid[1]  = 1'b0;
      @(posedge clk); #1;
      check("idle_after_accept", 32'(bus.resp_valid), 32'h0);
      drain();

      issue(0, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b0, 1'b1);
      drain();

      // Reset while requester 1's op is in EXEC: it must vanish.
      issue(1, ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midop_reset");
      reset = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(posedge clk); #1;
         check("no_resp_after_reset", 32'(bus.resp_valid), 32'h0);
      end

      // Both requesters held valid with resp_ready high.
`ifdef ALU_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      for (int k = 0; k < 4; k++)
         if (exp_order[k] == 0) sb.push_back('{0, 32'h0000_0030, 1'b0, 1'b0});
         else                   sb.push_back('{1, 32'h0000_00FF, 1'b0, 1'b0});
      g_idx.delete();
      g_cyc.delete();
      drive_req(0, ALU_AND, 32'h0000_00F0, 32'h0000_003C);
      drive_req(1, ALU_OR,  32'h0000_00F0, 32'h0000_000F);
      for (int t = 0; t < 40 && g_idx.size() < 4; t++) begin
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
      check("contend_grants", 32'(g_idx.size()), 32'd4);
      if (g_idx.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            check("contend_order", 32'(g_idx[k]), 32'(exp_order[k]));
            if (k > 0) check("contend_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
